// File: rtl/multicycle_control_unit_pkg.sv
// ============================================================================
// Module      : multicycle_control_unit_pkg
// Description : Shared state, instruction-class, opcode, ALU-code and mux-select
//               encodings for the multicycle RV32I control unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package multicycle_control_unit_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        CLS_ALU    = 3'd0,
        CLS_LOAD   = 3'd1,
        CLS_STORE  = 3'd2,
        CLS_BRANCH = 3'd3,
        CLS_JAL    = 3'd4,
        CLS_JALR   = 3'd5
    } insn_class_t;

    localparam logic [6:0] c_opc_op     = 7'b0110011;
    localparam logic [6:0] c_opc_op_imm = 7'b0010011;
    localparam logic [6:0] c_opc_lui    = 7'b0110111;
    localparam logic [6:0] c_opc_auipc  = 7'b0010111;
    localparam logic [6:0] c_opc_jal    = 7'b1101111;
    localparam logic [6:0] c_opc_jalr   = 7'b1100111;
    localparam logic [6:0] c_opc_branch = 7'b1100011;
    localparam logic [6:0] c_opc_load   = 7'b0000011;
    localparam logic [6:0] c_opc_store  = 7'b0100011;

    localparam logic [4:0] c_alu_nop  = 5'd0;
    localparam logic [4:0] c_alu_add  = 5'd1;
    localparam logic [4:0] c_alu_sub  = 5'd2;
    localparam logic [4:0] c_alu_sll  = 5'd3;
    localparam logic [4:0] c_alu_slt  = 5'd4;
    localparam logic [4:0] c_alu_sltu = 5'd5;
    localparam logic [4:0] c_alu_xor  = 5'd6;
    localparam logic [4:0] c_alu_srl  = 5'd7;
    localparam logic [4:0] c_alu_sra  = 5'd8;
    localparam logic [4:0] c_alu_or   = 5'd9;
    localparam logic [4:0] c_alu_and  = 5'd10;

    localparam logic [1:0] c_pc_plus4 = 2'd0;
    localparam logic [1:0] c_pc_imm   = 2'd1;
    localparam logic [1:0] c_pc_alu   = 2'd2;

    localparam logic [1:0] c_res_alu  = 2'd0;
    localparam logic [1:0] c_res_mem  = 2'd1;
    localparam logic [1:0] c_res_pc4  = 2'd2;

    // alt selects SUB (funct3=0) or SRA (funct3=5); callers qualify it.
    function automatic logic [4:0] f_alu_arith(input logic [2:0] funct3, input logic alt);
        case (funct3)
            3'd0:    return alt ? c_alu_sub : c_alu_add;
            3'd1:    return c_alu_sll;
            3'd2:    return c_alu_slt;
            3'd3:    return c_alu_sltu;
            3'd4:    return c_alu_xor;
            3'd5:    return alt ? c_alu_sra : c_alu_srl;
            3'd6:    return c_alu_or;
            default: return c_alu_and;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/multicycle_control_unit_insn_decoder.sv
// ============================================================================
// Module      : insn_decoder
// Description : Combinational RV32I decode: ALU operation, operand selects,
//               instruction class and legality.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module insn_decoder
    import multicycle_control_unit_pkg::*;
(
    input  logic [6:0]  i_opcode,
    input  logic [2:0]  i_funct3,
    input  logic [6:0]  i_funct7,
    output logic [4:0]  o_alu_op,
    output logic        o_alu_src_a,
    output logic        o_alu_src_b,
    output insn_class_t o_cls,
    output logic        o_legal
);

    always_comb begin
        o_alu_op    = c_alu_add;
        o_alu_src_a = 1'b0;
        o_alu_src_b = 1'b1;
        o_cls       = CLS_ALU;
        o_legal     = 1'b1;
        case (i_opcode)
            c_opc_op: begin
                o_alu_src_b = 1'b0;
                o_alu_op    = f_alu_arith(i_funct3, i_funct7[5]);
                o_legal     = (i_funct7 == 7'b0000000) ||
                              ((i_funct7 == 7'b0100000) && ((i_funct3 == 3'd0) || (i_funct3 == 3'd5)));
            end
            c_opc_op_imm: begin
                o_alu_op = f_alu_arith(i_funct3, (i_funct3 == 3'd5) && i_funct7[5]);
                if (i_funct3 == 3'd1)
                    o_legal = (i_funct7 == 7'b0000000);
                else if (i_funct3 == 3'd5)
                    o_legal = (i_funct7 == 7'b0000000) || (i_funct7 == 7'b0100000);
            end
            c_opc_lui:   o_alu_op = c_alu_add;
            c_opc_auipc: o_alu_src_a = 1'b1;
            c_opc_jal: begin
                o_alu_op = c_alu_nop;
                o_cls    = CLS_JAL;
            end
            c_opc_jalr: begin
                o_cls   = CLS_JALR;
                o_legal = (i_funct3 == 3'd0);
            end
            c_opc_branch: begin
                o_alu_op    = c_alu_sub;
                o_alu_src_b = 1'b0;
                o_cls       = CLS_BRANCH;
                o_legal     = (i_funct3 != 3'd2) && (i_funct3 != 3'd3);
            end
            c_opc_load: begin
                o_cls   = CLS_LOAD;
                o_legal = i_funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
            end
            c_opc_store: begin
                o_cls   = CLS_STORE;
                o_legal = (i_funct3 <= 3'd2);
            end
            default: o_legal = 1'b0;
        endcase

        if (!o_legal) begin
            o_alu_op    = c_alu_nop;
            o_alu_src_a = 1'b0;
            o_alu_src_b = 1'b0;
            o_cls       = CLS_ALU;
        end
    end

endmodule

`default_nettype wire

// File: rtl/multicycle_control_unit.sv
// ============================================================================
// Module      : multicycle_control_unit
// Description : Multicycle RV32I control FSM with handshake timeout and trap.
//               Macro ILLEGAL_INSN_TRAP_EN: illegal instructions trap instead
//               of retiring as a NOP.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_control_unit
    import multicycle_control_unit_pkg::*;
#(
    parameter int ALU_CTRL_W  = 5,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [31:0]           instr,
    output logic                  imem_req,
    input  logic                  imem_ready,
    output logic                  dmem_req,
    output logic                  dmem_we,
    input  logic                  dmem_ready,
    input  logic                  br_taken,
    output logic                  ir_we,
    output logic                  pc_we,
    output logic [1:0]            pc_src,
    output logic                  reg_we,
    output logic                  alu_src_a,
    output logic                  alu_src_b,
    output logic [1:0]            result_src,
    output logic [ALU_CTRL_W-1:0] alu_ctrl,
    output logic                  trap,
    output logic [2:0]            state_o
);

    localparam int c_cnt_w = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

    state_t              r_state;
    state_t              w_state_next;
    logic [c_cnt_w-1:0]  r_wait_cnt;
    logic [4:0]          w_alu_op;
    logic                w_src_a;
    logic                w_src_b;
    insn_class_t         w_cls;
    logic                w_legal;
    logic                w_rd_nz;
    logic                w_waiting;
    logic                w_timeout;
    logic                w_unused_rs;

    insn_decoder u_insn_decoder (
        .i_opcode    (instr[6:0]),
        .i_funct3    (instr[14:12]),
        .i_funct7    (instr[31:25]),
        .o_alu_op    (w_alu_op),
        .o_alu_src_a (w_src_a),
        .o_alu_src_b (w_src_b),
        .o_cls       (w_cls),
        .o_legal     (w_legal)
    );

    assign w_rd_nz     = (instr[11:7] != 5'd0);
    assign w_unused_rs = ^instr[24:15];
    assign state_o     = r_state;

    // The request is always high in FETCH/MEM, so "waiting" is just ready low there.
    assign w_waiting = ((r_state == ST_FETCH) && !imem_ready) ||
                       ((r_state == ST_MEM)   && !dmem_ready);
    // Trap after exactly MEM_TIMEOUT waiting cycles; a ready on that cycle is not waiting.
    assign w_timeout = (MEM_TIMEOUT != 0) && w_waiting &&
                       (r_wait_cnt == c_cnt_w'(MEM_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_state <= ST_FETCH;
        else
            r_state <= w_state_next;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_wait_cnt <= '0;
        else if (w_state_next != r_state)
            r_wait_cnt <= '0;
        else if (w_waiting)
            r_wait_cnt <= r_wait_cnt + 1'b1;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_FETCH: begin
                if (imem_ready)
                    w_state_next = ST_DECODE;
                else if (w_timeout)
                    w_state_next = ST_TRAP;
            end
            ST_DECODE: begin
                if (w_legal)
                    w_state_next = ST_EXEC;
                else begin
`ifdef ILLEGAL_INSN_TRAP_EN
                    w_state_next = ST_TRAP;
`else
                    w_state_next = ST_WB;
`endif
                end
            end
            ST_EXEC: begin
                case (w_cls)
                    CLS_BRANCH:          w_state_next = ST_FETCH;
                    CLS_LOAD, CLS_STORE: w_state_next = ST_MEM;
                    default:             w_state_next = ST_WB;
                endcase
            end
            ST_MEM: begin
                if (dmem_ready)
                    w_state_next = (w_cls == CLS_STORE) ? ST_FETCH : ST_WB;
                else if (w_timeout)
                    w_state_next = ST_TRAP;
            end
            ST_WB:   w_state_next = ST_FETCH;
            ST_TRAP: w_state_next = ST_TRAP;
            default: w_state_next = ST_TRAP;
        endcase
    end

    always_comb begin
        imem_req   = 1'b0;
        ir_we      = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        pc_we      = 1'b0;
        pc_src     = c_pc_plus4;
        reg_we     = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 1'b0;
        result_src = c_res_alu;
        alu_ctrl   = ALU_CTRL_W'(c_alu_nop);
        trap       = 1'b0;
        // Everything stays quiet while reset is held, regardless of stale state.
        if (rst_n) begin
            case (r_state)
                ST_FETCH: begin
                    imem_req = 1'b1;
                    ir_we    = imem_ready;
                end
                ST_EXEC: begin
                    alu_ctrl  = ALU_CTRL_W'(w_alu_op);
                    alu_src_a = w_src_a;
                    alu_src_b = w_src_b;
                    if (w_cls == CLS_BRANCH) begin
                        pc_we  = 1'b1;
                        pc_src = br_taken ? c_pc_imm : c_pc_plus4;
                    end
                end
                ST_MEM: begin
                    dmem_req = 1'b1;
                    dmem_we  = (w_cls == CLS_STORE);
                    pc_we    = dmem_ready && (w_cls == CLS_STORE);
                end
                ST_WB: begin
                    pc_we  = 1'b1;
                    reg_we = w_legal && w_rd_nz;
                    case (w_cls)
                        CLS_LOAD: result_src = c_res_mem;
                        CLS_JAL: begin
                            result_src = c_res_pc4;
                            pc_src     = c_pc_imm;
                        end
                        CLS_JALR: begin
                            result_src = c_res_pc4;
                            pc_src     = c_pc_alu;
                        end
                        default: ;
                    endcase
                end
                ST_TRAP: trap = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control_unit.sv
// ============================================================================
// Module      : tb_multicycle_control_unit
// Description : Directed self-checking bench: per-instruction cycle traces are
//               built from the phase rules, then checked against the DUT.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_multicycle_control_unit;
    import multicycle_control_unit_pkg::*;

    localparam int TMO = 16;
    localparam int E_IMEM = 6, E_IR = 5, E_DREQ = 4, E_DWE = 3, E_PC = 2, E_REG = 1, E_TRAP = 0;
    localparam int K_ALU = 0, K_LOAD = 1, K_STORE = 2, K_BR = 3, K_JAL = 4, K_JALR = 5, K_ILL = 6;

    logic        clk = 1'b0;
    logic        rst_n, imem_ready, dmem_ready, br_taken;
    logic [31:0] instr;
    logic        imem_req, dmem_req, dmem_we, ir_we, pc_we, reg_we;
    logic        alu_src_a, alu_src_b, trap;
    logic [1:0]  pc_src, result_src;
    logic [4:0]  alu_ctrl;
    logic [2:0]  state_o;

    always #5 clk = ~clk;

    multicycle_control_unit #(.ALU_CTRL_W(5), .MEM_TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .instr(instr),
        .imem_req(imem_req), .imem_ready(imem_ready),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
        .br_taken(br_taken), .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src),
        .reg_we(reg_we), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .result_src(result_src), .alu_ctrl(alu_ctrl), .trap(trap), .state_o(state_o)
    );

    typedef struct {
        logic        rst_n, imem_ready, dmem_ready, br_taken;
        logic [31:0] instr;
        logic [6:0]  en;
        logic        chk_pc;  logic [1:0] pc_src;
        logic        chk_res; logic [1:0] res;
        logic        chk_alu; logic [4:0] alu;
        logic        chk_src; logic a, b;
    } cyc_t;

    typedef struct {
        logic [31:0] instr;
        int          kind;
        logic [4:0]  alu;
        logic        a, b;
    } insn_t;

    cyc_t        q[$];
    cyc_t        cur;
    logic        exp_valid = 1'b0;
    logic [31:0] cur_instr = 32'h0;
    int          n_cmp = 0, n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", nm, $time, act, exp);
        end
    endtask

    function automatic insn_t mk(logic [31:0] i, int k, logic [4:0] op, logic sa, logic sb);
        insn_t d;
        d.instr = i; d.kind = k; d.alu = op; d.a = sa; d.b = sb;
        return d;
    endfunction

    // Default cycle: readies/branch are noise that must not matter, nothing expected on.
    function automatic cyc_t blank();
        cyc_t c;
        c.rst_n = 1'b1;
        c.imem_ready = 1'($urandom);
        c.dmem_ready = 1'($urandom);
        c.br_taken = 1'($urandom);
        c.instr = cur_instr;
        c.en = '0;
        c.chk_pc = 1'b0;  c.pc_src = 2'd0;
        c.chk_res = 1'b0; c.res = 2'd0;
        c.chk_alu = 1'b0; c.alu = 5'd0;
        c.chk_src = 1'b0; c.a = 1'b0; c.b = 1'b0;
        return c;
    endfunction

    task automatic add_reset(input int n);
        cyc_t c;
        for (int i = 0; i < n; i++) begin
            c = blank(); c.rst_n = 1'b0; c.chk_alu = 1'b1; c.alu = c_alu_nop;
            q.push_back(c);
        end
    endtask

    task automatic add_trap_reset();
        cyc_t c;
        for (int i = 0; i < 3; i++) begin
            c = blank(); c.en[E_TRAP] = 1'b1; q.push_back(c);
        end
        add_reset(2);
    endtask

    task automatic add_insn(input insn_t d, input int wi, input int wd, input logic br, input int abort_at);
        cyc_t c;
        logic rdnz;
        rdnz = (d.instr[11:7] != 5'd0);
        for (int i = 0; i < wi && i < TMO; i++) begin
            c = blank(); c.imem_ready = 1'b0; c.en[E_IMEM] = 1'b1; q.push_back(c);
        end
        if (wi >= TMO) begin add_trap_reset(); return; end
        c = blank(); c.imem_ready = 1'b1; c.en[E_IMEM] = 1'b1; c.en[E_IR] = 1'b1; q.push_back(c);
        cur_instr = d.instr;
        c = blank(); q.push_back(c);
        if (d.kind == K_ILL) begin
`ifdef ILLEGAL_INSN_TRAP_EN
            add_trap_reset();
`else
            c = blank(); c.en[E_PC] = 1'b1; c.chk_pc = 1'b1; c.pc_src = c_pc_plus4; q.push_back(c);
`endif
            return;
        end
        c = blank();
        c.chk_alu = 1'b1; c.alu = d.alu; c.chk_src = 1'b1; c.a = d.a; c.b = d.b;
        if (d.kind == K_BR) begin
            c.br_taken = br; c.en[E_PC] = 1'b1; c.chk_pc = 1'b1;
            c.pc_src = br ? c_pc_imm : c_pc_plus4;
            q.push_back(c);
            return;
        end
        q.push_back(c);
        if (d.kind == K_LOAD || d.kind == K_STORE) begin
            for (int i = 0; i < wd && i < TMO; i++) begin
                if (i == abort_at) begin add_reset(1); return; end
                c = blank(); c.dmem_ready = 1'b0; c.en[E_DREQ] = 1'b1;
                c.en[E_DWE] = (d.kind == K_STORE); q.push_back(c);
            end
            if (wd >= TMO) begin add_trap_reset(); return; end
            c = blank(); c.dmem_ready = 1'b1; c.en[E_DREQ] = 1'b1; c.en[E_DWE] = (d.kind == K_STORE);
            if (d.kind == K_STORE) begin
                c.en[E_PC] = 1'b1; c.chk_pc = 1'b1; c.pc_src = c_pc_plus4;
                q.push_back(c);
                return;
            end
            q.push_back(c);
        end
        c = blank();
        c.en[E_PC] = 1'b1; c.en[E_REG] = rdnz; c.chk_pc = 1'b1; c.chk_res = rdnz;
        c.pc_src = (d.kind == K_JAL) ? c_pc_imm : (d.kind == K_JALR) ? c_pc_alu : c_pc_plus4;
        c.res = (d.kind == K_LOAD) ? c_res_mem : (d.kind == K_JAL || d.kind == K_JALR) ? c_res_pc4 : c_res_alu;
        q.push_back(c);
    endtask

    always @(negedge clk) begin
        if (exp_valid) begin
            chk("enables{imem,ir,dreq,dwe,pc,reg,trap}",
                32'({imem_req, ir_we, dmem_req, dmem_we, pc_we, reg_we, trap}), 32'(cur.en));
            if (cur.chk_pc)  chk("pc_src", 32'(pc_src), 32'(cur.pc_src));
            if (cur.chk_res) chk("result_src", 32'(result_src), 32'(cur.res));
            if (cur.chk_alu) chk("alu_ctrl", 32'(alu_ctrl), 32'(cur.alu));
            if (cur.chk_src) chk("alu_src{a,b}", 32'({alu_src_a, alu_src_b}), 32'({cur.a, cur.b}));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        int    s, nd, nw;
        insn_t add_i, lw_i, sw_i, beq_i, jalr_i;
        rst_n = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0; br_taken = 1'b0; instr = 32'h0;

        add_i  = mk(32'h002081B3, K_ALU,  c_alu_add, 1'b0, 1'b0);
        lw_i   = mk(32'h0080A383, K_LOAD, c_alu_add, 1'b0, 1'b1);
        sw_i   = mk(32'h0020A223, K_STORE, c_alu_add, 1'b0, 1'b1);
        beq_i  = mk(32'h00208463, K_BR,   c_alu_sub, 1'b0, 1'b0);
        jalr_i = mk(32'h000280E7, K_JALR, c_alu_add, 1'b0, 1'b1);

        add_reset(2);
        s = q.size();
        add_insn(add_i, 0, 0, 1'b0, -1);
        chk("pin_add_len", 32'(q.size() - s), 32'd4);
        chk("pin_add_ir_c0", 32'(q[s].en), 32'b1100000);
        chk("pin_add_wb_c3", 32'({q[s+3].en[E_REG], q[s+3].res}), 32'b100);
        add_insn(mk(32'h407302B3, K_ALU, c_alu_sub, 1'b0, 1'b0), 2, 0, 1'b0, -1);
        chk("pin_add_next_imem_c4", 32'(q[s+4].en[E_IMEM]), 32'd1);
        add_insn(mk(32'h00000013, K_ALU, c_alu_add, 1'b0, 1'b1), 0, 0, 1'b0, -1);
        add_insn(mk(32'h40325213, K_ALU, c_alu_sra, 1'b0, 1'b1), 0, 0, 1'b0, -1);
        add_insn(mk(32'h12345137, K_ALU, c_alu_add, 1'b0, 1'b1), 0, 0, 1'b0, -1);
        add_insn(mk(32'h00001317, K_ALU, c_alu_add, 1'b1, 1'b1), 1, 0, 1'b0, -1);

        s = q.size();
        add_insn(lw_i, 0, 3, 1'b0, -1);
        nd = 0; nw = 0;
        for (int i = s; i < q.size(); i++) begin
            nd += int'(q[i].en[E_DREQ]);
            nw += int'(q[i].en[E_DWE]);
        end
        chk("pin_lw_len", 32'(q.size() - s), 32'd8);
        chk("pin_lw_dreq_cycles", 32'(nd), 32'd4);
        chk("pin_lw_dwe_cycles", 32'(nw), 32'd0);
        chk("pin_lw_wb_res", 32'(q[q.size()-1].res), 32'd1);

        add_insn(sw_i, 0, 0, 1'b0, -1);
        add_insn(sw_i, 0, 2, 1'b0, -1);
        add_insn(beq_i, 0, 0, 1'b1, -1);
        add_insn(beq_i, 0, 0, 1'b0, -1);
        add_insn(mk(32'h010000EF, K_JAL, c_alu_nop, 1'b0, 1'b1), 0, 0, 1'b0, -1);
        add_insn(jalr_i, 0, 0, 1'b0, -1);
        chk("pin_jalr_wb", 32'({q[q.size()-1].en[E_REG], q[q.size()-1].res, q[q.size()-1].pc_src}), 32'b11010);

        add_insn(lw_i, 0, TMO - 1, 1'b0, -1);
        add_insn(add_i, TMO - 1, 0, 1'b0, -1);
        add_insn(mk(32'h00000000, K_ILL, c_alu_nop, 1'b0, 1'b0), 0, 0, 1'b0, -1);
        add_insn(mk(32'h022081B3, K_ILL, c_alu_nop, 1'b0, 1'b0), 0, 0, 1'b0, -1);
        add_insn(add_i, TMO, 0, 1'b0, -1);
        add_insn(add_i, 0, 0, 1'b0, -1);
        add_insn(lw_i, 0, 5, 1'b0, 2);
        add_insn(lw_i, 0, TMO, 1'b0, -1);
        add_insn(add_i, 0, 0, 1'b0, -1);

        foreach (q[i]) begin
            @(posedge clk);
            #1;
            cur        = q[i];
            rst_n      = cur.rst_n;
            imem_ready = cur.imem_ready;
            dmem_ready = cur.dmem_ready;
            br_taken   = cur.br_taken;
            instr      = cur.instr;
            exp_valid  = 1'b1;
        end
        @(posedge clk);
        #1 exp_valid = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
